bridge_arq_tx: RTL and testbench

Second-generation bridge TX engine. It replaces the single-slot command register with a parametrised command queue, per-packet sequence numbers and checksums, and ACK/NACK-driven retransmission with timeout. It sits between the SPI register block, which pushes commands, and the UART transmitter. An upstream RX parser supplies decoded ACK/NACK events.

---
 rtl/bridge_arq_tx.sv | 259 +++++++++++++++++++++++++
 tb/tb_bridge_arq_tx.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bridge_arq_tx.sv
// Bridge TX engine: command queue -> framed packets (SYNC,CMD,SEQ,payload,CHK) with ACK/NACK retransmit.
// Latency: first byte on tx 2 edges after a push into an empty idle queue; 1 idle cycle between packets.
// Backpressure: tx bytes held until tx_ready; cmd_ready low while the queue is full (a same-cycle pop does not relieve it).
module bridge_arq_tx #(
  parameter int         CMD_DEPTH   = 4,
  parameter int         MAX_PAYLOAD = 6,
  parameter int         ACK_TIMEOUT = 48_000,
  parameter int         MAX_RETRIES = 3,
  parameter logic [7:0] SYNC_BYTE   = 8'hAA
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic [7:0]                         cmd_type,
  input  logic [$clog2(MAX_PAYLOAD+1)-1:0]   cmd_len,
  input  logic                               cmd_noack,
  input  logic [8*MAX_PAYLOAD-1:0]           cmd_payload,
  input  logic                               flush,
  output logic [7:0]                         tx_data,
  output logic                               tx_valid,
  input  logic                               tx_ready,
  input  logic                               ack_valid,
  input  logic [7:0]                         ack_seq,
  input  logic                               ack_nack,
  output logic                               busy,
  output logic [$clog2(CMD_DEPTH+1)-1:0]     q_count,
  output logic                               done_pulse,
  output logic                               fail_pulse,
  output logic [15:0]                        retry_count,
  output logic [15:0]                        fail_count
);

  localparam int LW = $clog2(MAX_PAYLOAD + 1);
  localparam int QW = $clog2(CMD_DEPTH + 1);
  localparam int PW = $clog2(CMD_DEPTH);
  localparam int IW = $clog2(MAX_PAYLOAD + 4);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int AW = $clog2(MAX_RETRIES + 2);
  localparam int PB = 8 * MAX_PAYLOAD;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

  // Queue storage (no reset needed: only read when q_count says the slot is valid)
  logic [7:0]    q_type_q  [CMD_DEPTH];
  logic [LW-1:0] q_len_q   [CMD_DEPTH];
  logic          q_noack_q [CMD_DEPTH];
  logic [PB-1:0] q_pay_q   [CMD_DEPTH];

  state_t        state_q, state_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [QW-1:0] count_q, count_d;
  logic [7:0]    seq_q, seq_d, chk_q, chk_d, tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d, done_q, done_d, fail_q, fail_d;
  logic [IW-1:0] byte_idx_q, byte_idx_d;
  logic [AW-1:0] attempt_q, attempt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0]   retry_q, retry_d, fail_cnt_q, fail_cnt_d;
  logic [7:0]    cur_type_q, cur_type_d;
  logic [LW-1:0] cur_len_q, cur_len_d;
  logic          cur_noack_q, cur_noack_d;
  logic [PB-1:0] cur_pay_q, cur_pay_d;

  logic          push, pop;
  logic [LW-1:0] push_len;
  logic [7:0]    head_chk, nxt_byte;
  logic [IW-1:0] nxt_idx, last_idx;
  logic          ack_match;

  assign cmd_ready   = (count_q < QW'(CMD_DEPTH));
  assign push        = cmd_valid && cmd_ready && !flush;
  assign push_len    = (cmd_len > LW'(MAX_PAYLOAD)) ? LW'(MAX_PAYLOAD) : cmd_len;
  assign last_idx    = IW'(cur_len_q) + IW'(3);
  assign ack_match   = ack_valid && (ack_seq == seq_q);

  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign busy        = (state_q != S_IDLE);
  assign q_count     = count_q;
  assign done_pulse  = done_q;
  assign fail_pulse  = fail_q;
  assign retry_count = retry_q;
  assign fail_count  = fail_cnt_q;

  // Write the accepted command (length already clamped) into the tail slot
  always_ff @(posedge clk) begin
    if (push) begin
      q_type_q[wr_ptr_q]  <= cmd_type;
      q_len_q[wr_ptr_q]   <= push_len;
      q_noack_q[wr_ptr_q] <= cmd_noack;
      q_pay_q[wr_ptr_q]   <= cmd_payload;
    end
  end

  // Checksum of the head entry with the current sequence number, taken at latch time
  always_comb begin
    head_chk = q_type_q[rd_ptr_q] + seq_q;
    for (int k = 0; k < MAX_PAYLOAD; k++) begin
      if (LW'(k) < q_len_q[rd_ptr_q]) head_chk = head_chk + q_pay_q[rd_ptr_q][8*k +: 8];
    end
  end

  // Byte that follows the one currently on the tx port
  always_comb begin
    nxt_idx  = byte_idx_q + IW'(1);
    nxt_byte = chk_q;
    for (int k = 0; k < MAX_PAYLOAD; k++) begin
      if (nxt_idx == IW'(k + 3)) nxt_byte = cur_pay_q[8*k +: 8];
    end
    if (nxt_idx == IW'(1)) nxt_byte = cur_type_q;
    if (nxt_idx == IW'(2)) nxt_byte = seq_q;
    if (nxt_idx == last_idx) nxt_byte = chk_q;
  end

  // FSM and queue control next-state
  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    seq_d       = seq_q;
    chk_d       = chk_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    done_d      = 1'b0;
    fail_d      = 1'b0;
    byte_idx_d  = byte_idx_q;
    attempt_d   = attempt_q;
    timer_d     = timer_q;
    retry_d     = retry_q;
    fail_cnt_d  = fail_cnt_q;
    cur_type_d  = cur_type_q;
    cur_len_d   = cur_len_q;
    cur_noack_d = cur_noack_q;
    cur_pay_d   = cur_pay_q;
    pop         = 1'b0;

    if (flush) begin
      // Abort wins over everything; an in-flight sequence number is burned
      state_d    = S_IDLE;
      tx_valid_d = 1'b0;
      rd_ptr_d   = wr_ptr_q;
      if (state_q != S_IDLE) seq_d = seq_q + 8'd1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (count_q != '0) begin
            cur_type_d  = q_type_q[rd_ptr_q];
            cur_len_d   = q_len_q[rd_ptr_q];
            cur_noack_d = q_noack_q[rd_ptr_q];
            cur_pay_d   = q_pay_q[rd_ptr_q];
            chk_d       = head_chk;
            byte_idx_d  = '0;
            attempt_d   = '0;
            tx_valid_d  = 1'b1;
            tx_data_d   = SYNC_BYTE;
            state_d     = S_SEND;
          end
        end
        S_SEND: begin
          if (tx_ready) begin
            if (byte_idx_q == last_idx) begin
              tx_valid_d = 1'b0;
              if (cur_noack_q) begin
                pop     = 1'b1;
                done_d  = 1'b1;
                state_d = S_IDLE;
              end else begin
                timer_d = '0;
                state_d = S_WAIT;
              end
            end else begin
              byte_idx_d = nxt_idx;
              tx_data_d  = nxt_byte;
            end
          end
        end
        S_WAIT: begin
          timer_d = timer_q + TW'(1);
          if (ack_match && !ack_nack) begin
            pop     = 1'b1;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else if ((ack_match && ack_nack) || (timer_q == TW'(ACK_TIMEOUT - 1))) begin
            if (attempt_q < AW'(MAX_RETRIES)) begin
              attempt_d  = attempt_q + AW'(1);
              retry_d    = (retry_q == 16'hFFFF) ? retry_q : retry_q + 16'd1;
              byte_idx_d = '0;
              tx_valid_d = 1'b1;
              tx_data_d  = SYNC_BYTE;
              state_d    = S_SEND;
            end else begin
              pop        = 1'b1;
              fail_d     = 1'b1;
              fail_cnt_d = (fail_cnt_q == 16'hFFFF) ? fail_cnt_q : fail_cnt_q + 16'd1;
              state_d    = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        seq_d    = seq_q + 8'd1;
      end
    end

    if (flush)            count_d = '0;
    else if (push && !pop) count_d = count_q + QW'(1);
    else if (pop && !push) count_d = count_q - QW'(1);
    else                   count_d = count_q;
  end

  // Register all control state and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      seq_q       <= '0;
      chk_q       <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      byte_idx_q  <= '0;
      attempt_q   <= '0;
      timer_q     <= '0;
      retry_q     <= '0;
      fail_cnt_q  <= '0;
      cur_type_q  <= '0;
      cur_len_q   <= '0;
      cur_noack_q <= 1'b0;
      cur_pay_q   <= '0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      seq_q       <= seq_d;
      chk_q       <= chk_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      byte_idx_q  <= byte_idx_d;
      attempt_q   <= attempt_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      fail_cnt_q  <= fail_cnt_d;
      cur_type_q  <= cur_type_d;
      cur_len_q   <= cur_len_d;
      cur_noack_q <= cur_noack_d;
      cur_pay_q   <= cur_pay_d;
    end
  end

endmodule

// File: tb/tb_bridge_arq_tx.sv
// Directed bench for bridge_arq_tx: framing, ACK/NACK retry, timeout fail, queue full, no-ack, flush.
// Expected bytes come from a tiny packet builder; checksum computed from the byte list.
// Short ACK timeout keeps the run small.
module tb_bridge_arq_tx;

  localparam int T = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_noack, flush;
  logic [7:0]  cmd_type;
  logic [2:0]  cmd_len;
  logic [47:0] cmd_payload;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic        ack_valid, ack_nack;
  logic [7:0]  ack_seq;
  logic        busy, done_pulse, fail_pulse;
  logic [2:0]  q_count;
  logic [15:0] retry_count, fail_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bridge_arq_tx #(
    .CMD_DEPTH(4), .MAX_PAYLOAD(6), .ACK_TIMEOUT(T), .MAX_RETRIES(3), .SYNC_BYTE(8'hAA)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type), .cmd_len(cmd_len),
    .cmd_noack(cmd_noack), .cmd_payload(cmd_payload), .flush(flush),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ack_valid(ack_valid), .ack_seq(ack_seq), .ack_nack(ack_nack),
    .busy(busy), .q_count(q_count), .done_pulse(done_pulse), .fail_pulse(fail_pulse),
    .retry_count(retry_count), .fail_count(fail_count)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] calc_chk(input logic [7:0] typ, input logic [7:0] seq,
                                          input int len, input logic [47:0] pay);
    logic [7:0] s;
    s = typ + seq;
    for (int k = 0; k < len; k++) s = s + pay[8*k +: 8];
    return s;
  endfunction

  task automatic push_set(input logic [7:0] typ, input logic [2:0] len, input logic noack,
                          input logic [47:0] pay);
    cmd_valid   = 1'b1;
    cmd_type    = typ;
    cmd_len     = len;
    cmd_noack   = noack;
    cmd_payload = pay;
  endtask

  task automatic send_ack(input logic [7:0] seq, input logic nack);
    ack_valid = 1'b1;
    ack_seq   = seq;
    ack_nack  = nack;
    step;
    ack_valid = 1'b0;
  endtask

  // Waits (bounded) for tx_valid, then checks every byte of the packet with tx_ready high
  task automatic expect_packet(input string tag, input logic [7:0] typ, input logic [7:0] seq,
                               input int len, input logic [47:0] pay);
    logic [7:0] exp [10];
    int n;
    exp[0] = 8'hAA;
    exp[1] = typ;
    exp[2] = seq;
    for (int k = 0; k < len; k++) exp[3+k] = pay[8*k +: 8];
    exp[len+3] = calc_chk(typ, seq, len, pay);
    n = 0;
    while (tx_valid !== 1'b1 && n < 60) begin
      step;
      n++;
    end
    check($sformatf("%s start", tag), {31'd0, tx_valid}, 32'd1);
    for (int i = 0; i < len + 4; i++) begin
      check($sformatf("%s byte%0d", tag, i), {23'd0, tx_valid, tx_data}, {24'd1, exp[i]});
      step;
    end
    check($sformatf("%s end", tag), {31'd0, tx_valid}, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_type = '0; cmd_len = '0; cmd_noack = 1'b0;
    cmd_payload = '0; flush = 1'b0; tx_ready = 1'b1; ack_valid = 1'b0; ack_seq = '0; ack_nack = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step;

    // Reset state
    check("rst tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst tx_data", {24'd0, tx_data}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst q_count", {29'd0, q_count}, 32'd0);
    check("rst cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst pulses", {30'd0, done_pulse, fail_pulse}, 32'd0);
    check("rst counters", {retry_count, fail_count}, 32'd0);

    // MOVE, seq 0, then ACK
    push_set(8'h01, 3'd4, 1'b0, 48'h0000_FFFF_0001);
    step;
    cmd_valid = 1'b0;
    check("lat edge1 tx_valid", {31'd0, tx_valid}, 32'd0);
    check("lat edge1 q_count", {29'd0, q_count}, 32'd1);
    step;
    check("lat edge2 sync", {23'd0, tx_valid, tx_data}, {24'd1, 8'hAA});
    expect_packet("move", 8'h01, 8'h00, 4, 48'h0000_FFFF_0001);
    check("move wait busy", {31'd0, busy}, 32'd1);
    send_ack(8'h00, 1'b0);
    check("move done", {31'd0, done_pulse}, 32'd1);
    check("move q_count", {29'd0, q_count}, 32'd0);
    check("move idle", {31'd0, busy}, 32'd0);
    step;
    check("move done single", {31'd0, done_pulse}, 32'd0);
    send_ack(8'h01, 1'b0);
    check("idle ack ignored", {30'd0, done_pulse, busy}, 32'd0);

    // NACK, NACK, ACK on seq 1
    push_set(8'h22, 3'd2, 1'b0, 48'h4433);
    step;
    cmd_valid = 1'b0;
    expect_packet("nk0", 8'h22, 8'h01, 2, 48'h4433);
    send_ack(8'h01, 1'b1);
    check("nk1 resend", {23'd0, tx_valid, tx_data}, {24'd1, 8'hAA});
    check("nk1 retry", {16'd0, retry_count}, 32'd1);
    check("nk1 no done", {31'd0, done_pulse}, 32'd0);
    expect_packet("nk1", 8'h22, 8'h01, 2, 48'h4433);
    send_ack(8'h01, 1'b1);
    check("nk2 retry", {16'd0, retry_count}, 32'd2);
    expect_packet("nk2", 8'h22, 8'h01, 2, 48'h4433);
    send_ack(8'h01, 1'b0);
    check("nk done", {31'd0, done_pulse}, 32'd1);
    step;
    check("nk done single", {31'd0, done_pulse}, 32'd0);
    check("nk retry final", {16'd0, retry_count}, 32'd2);

    // No ACK at all on seq 2: 4 transmissions, then fail
    push_set(8'h33, 3'd1, 1'b0, 48'h55);
    step;
    cmd_valid = 1'b0;
    expect_packet("to0", 8'h33, 8'h02, 1, 48'h55);
    for (int r = 1; r <= 3; r++) begin
      n = 0;
      while (tx_valid !== 1'b1 && n < 100) begin
        n++;
        step;
      end
      check($sformatf("to%0d gap", r), n, T);
      check($sformatf("to%0d retry", r), {16'd0, retry_count}, 32'(2 + r));
      expect_packet($sformatf("to%0d", r), 8'h33, 8'h02, 1, 48'h55);
    end
    n = 0;
    while (fail_pulse !== 1'b1 && n < 100) begin
      n++;
      step;
    end
    check("to fail gap", n, T);
    check("to fail_count", {16'd0, fail_count}, 32'd1);
    check("to retry total", {16'd0, retry_count}, 32'd5);
    check("to q_count", {29'd0, q_count}, 32'd0);
    check("to done none", {31'd0, done_pulse}, 32'd0);
    step;
    check("to fail single", {31'd0, fail_pulse}, 32'd0);

    // Fire-and-forget, L=0, seq 3
    push_set(8'h10, 3'd0, 1'b1, 48'h0);
    step;
    cmd_valid = 1'b0;
    expect_packet("noack", 8'h10, 8'h03, 0, 48'h0);
    check("noack done", {31'd0, done_pulse}, 32'd1);
    check("noack no wait", {31'd0, busy}, 32'd0);

    // Mismatched ACK/NACK ignored on seq 4
    push_set(8'h44, 3'd0, 1'b0, 48'h0);
    step;
    cmd_valid = 1'b0;
    expect_packet("mis", 8'h44, 8'h04, 0, 48'h0);
    send_ack(8'h05, 1'b0);
    check("mis ack", {29'd0, done_pulse, busy, q_count == 3'd1}, 32'b011);
    send_ack(8'h03, 1'b1);
    check("mis nack", {29'd0, tx_valid, busy, fail_pulse}, 32'b010);
    check("mis retry", {16'd0, retry_count}, 32'd5);
    send_ack(8'h04, 1'b0);
    check("mis done", {31'd0, done_pulse}, 32'd1);

    // Fill the queue while the head is stalled by tx_ready low
    tx_ready = 1'b0;
    push_set(8'h66, 3'd0, 1'b1, 48'h0);
    step;
    push_set(8'h77, 3'd7, 1'b0, 48'h0605_0403_0201);
    step;
    push_set(8'h88, 3'd1, 1'b0, 48'h1);
    step;
    push_set(8'h99, 3'd1, 1'b0, 48'h2);
    step;
    check("full q_count", {29'd0, q_count}, 32'd4);
    check("full cmd_ready", {31'd0, cmd_ready}, 32'd0);
    push_set(8'hAB, 3'd1, 1'b0, 48'h3);
    step;
    check("full refused", {29'd0, q_count}, 32'd4);
    check("stall hold", {23'd0, tx_valid, tx_data}, {24'd1, 8'hAA});
    tx_ready = 1'b1;
    expect_packet("qhead", 8'h66, 8'h05, 0, 48'h0);
    check("pop refuses push", {29'd0, q_count}, 32'd3);
    check("pop done", {30'd0, done_pulse, cmd_ready}, 32'b11);
    step;
    cmd_valid = 1'b0;
    check("held push lands", {29'd0, q_count}, 32'd4);
    check("next head sync", {23'd0, tx_valid, tx_data}, {24'd1, 8'hAA});

    // Flush mid-SEND with tx_ready toggling (head seq 6)
    tx_ready = 1'b0;
    step;
    check("tog hold sync", {23'd0, tx_valid, tx_data}, {24'd1, 8'hAA});
    tx_ready = 1'b1;
    step;
    check("tog cmd", {23'd0, tx_valid, tx_data}, {24'd1, 8'h77});
    tx_ready = 1'b0;
    step;
    check("tog hold cmd", {23'd0, tx_valid, tx_data}, {24'd1, 8'h77});
    tx_ready = 1'b1;
    step;
    check("tog seq", {23'd0, tx_valid, tx_data}, {24'd1, 8'h06});
    flush = 1'b1;
    tx_ready = 1'b0;
    step;
    flush = 1'b0;
    check("flush tx_valid", {31'd0, tx_valid}, 32'd0);
    check("flush q_count", {29'd0, q_count}, 32'd0);
    check("flush idle", {30'd0, busy, cmd_ready}, 32'b01);
    check("flush no pulse", {30'd0, done_pulse, fail_pulse}, 32'd0);
    step;
    check("flush stays idle", {29'd0, tx_valid, done_pulse, fail_pulse}, 32'd0);
    tx_ready = 1'b1;

    // Next command uses seq 7; length 7 clamps to 6
    push_set(8'h5A, 3'd7, 1'b1, 48'h0605_0403_0201);
    step;
    cmd_valid = 1'b0;
    expect_packet("clamp", 8'h5A, 8'h07, 6, 48'h0605_0403_0201);
    check("clamp done", {31'd0, done_pulse}, 32'd1);
    check("final counters", {retry_count, fail_count}, {16'd5, 16'd1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
